// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The zero-init sweep is selected by the RF_ARB_INIT_EN macro in the top level.
package rf_arb_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;

    localparam int RF_ARB_DEPTH_DEF  = 4;
    localparam int RF_ARB_STARVE_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    function automatic logic [RF_NREG-1:0] reg_onehot(input logic [RF_AW-1:0] a);
        logic [RF_NREG-1:0] m;
        m    = '0;
        m[a] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO for secondary register writes; exposes every entry's
// address and valid bit so the arbiter can build the pending-register mask.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = RF_ARB_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [RF_AW-1:0]       push_addr,
    input  logic [RF_DW-1:0]       push_data,
    input  logic                   pop,
    output logic [RF_AW-1:0]       head_addr,
    output logic [RF_DW-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH*RF_AW-1:0] ent_addr,
    output logic [DEPTH-1:0]       ent_valid
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             push_ok, pop_ok;

    logic [RF_AW-1:0] addr_mem [DEPTH];
    logic [RF_DW-1:0] data_mem [DEPTH];

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        if (pop_ok) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push_ok) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage carries no reset; the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr_q];
    assign head_data = data_mem[rd_ptr_q];
    assign full      = full_q;
    assign empty     = empty_q;
    assign ent_valid = valid_q;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
        assign ent_addr[gi*RF_AW +: RF_AW] = addr_mem[gi];
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the pipeline and a buffered secondary
// writer. Define RF_ARB_INIT_EN to include the post-reset x1..x31 zero sweep.
module regfile_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH        = RF_ARB_DEPTH_DEF,
    parameter int STARVE_LIMIT = RF_ARB_STARVE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p_we,
    input  logic [RF_AW-1:0]   p_addr,
    input  logic [RF_DW-1:0]   p_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [RF_AW-1:0]   s_addr,
    input  logic [RF_DW-1:0]   s_data,
    output logic               rf_we,
    output logic [RF_AW-1:0]   rf_addr,
    output logic [RF_DW-1:0]   rf_wdata,
    output logic [RF_NREG-1:0] pend_mask,
    output logic               pipe_stall,
    output logic               init_busy
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic               init_wr;
    logic [RF_AW-1:0]   init_addr;

    logic               rf_we_q, rf_we_d;
    logic [RF_AW-1:0]   rf_addr_q, rf_addr_d;
    logic [RF_DW-1:0]   rf_wdata_q, rf_wdata_d;
    logic [SW-1:0]      starve_q, starve_d;
    logic               stall_q, stall_d;
    logic               alive_q;

    logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [RF_AW-1:0]   head_addr;
    logic [RF_DW-1:0]   head_data;
    logic [DEPTH*RF_AW-1:0] ent_addr;
    logic [DEPTH-1:0]   ent_valid;
    logic [RF_NREG-1:0] ent_mask [DEPTH];
    logic [RF_NREG-1:0] pend_raw;

`ifdef RF_ARB_INIT_EN
    arb_state_e         state_q, state_d;
    logic [RF_AW-1:0]   init_cnt_q, init_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= RF_AW'(1);
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Counter wraps 31 -> 0; the zero slot is the hand-off cycle into RUN.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            if (init_cnt_q != '0) begin
                init_cnt_d = init_cnt_q + RF_AW'(1);
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    assign init_wr   = (state_q == ST_INIT) && (init_cnt_q != '0);
    assign init_addr = init_cnt_q;
`else
    arb_state_e         state_q;

    assign state_q   = ST_RUN;
    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    // Holds s_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign s_ready   = alive_q && (state_q == ST_RUN) && !fifo_full;
    assign fifo_push = s_valid && s_ready && (s_addr != '0);

    rf_arb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_addr (s_addr),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .ent_addr  (ent_addr),
        .ent_valid (ent_valid)
    );

    always_comb begin
        rf_we_d    = 1'b0;
        rf_addr_d  = '0;
        rf_wdata_d = '0;
        fifo_pop   = 1'b0;
        if (state_q == ST_INIT) begin
            rf_we_d   = init_wr;
            rf_addr_d = init_addr;
        end else if (p_we && (p_addr != '0)) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = p_addr;
            rf_wdata_d = p_data;
        end else if (!fifo_empty) begin
            rf_we_d    = 1'b1;
            rf_addr_d  = head_addr;
            rf_wdata_d = head_data;
            fifo_pop   = 1'b1;
        end
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = stall_q;
        if (fifo_pop) begin
            starve_d = '0;
            stall_d  = 1'b0;
        end else begin
            if (!fifo_empty && (starve_q != SW'(STARVE_LIMIT))) begin
                starve_d = starve_q + SW'(1);
            end
            if (starve_d == SW'(STARVE_LIMIT)) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wdata_q <= rf_wdata_d;
            starve_q   <= starve_d;
            stall_q    <= stall_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
        assign ent_mask[gi] = ent_valid[gi] ? reg_onehot(ent_addr[gi*RF_AW +: RF_AW]) : '0;
    end

    always_comb begin
        pend_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_raw = pend_raw | ent_mask[i];
        end
    end

    assign pend_mask  = pend_raw & ~RF_NREG'(1);
    assign rf_we      = rf_we_q;
    assign rf_addr    = rf_addr_q;
    assign rf_wdata   = rf_wdata_q;
    assign pipe_stall = stall_q;
    assign init_busy  = (state_q == ST_INIT);

    // The pipeline must honour pipe_stall; it still wins arbitration if it does not.
    a_stall_contract: assert property (@(posedge clk) disable iff (!rst) !(p_we && pipe_stall));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized bench for regfile_write_arbiter against a queue-based reference model.
// Honours RF_ARB_INIT_EN the same way as the design.
module tb_regfile_write_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

`ifdef RF_ARB_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        p_we    = 1'b0;
    logic [4:0]  p_addr  = '0;
    logic [31:0] p_data  = '0;
    logic        s_valid = 1'b0;
    logic [4:0]  s_addr  = '0;
    logic [31:0] s_data  = '0;
    logic        s_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        pipe_stall;
    logic        init_busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    ent_t        q[$];
    bit          m_run;
    bit          m_alive;
    int          m_init_step;
    int          m_wait;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .p_we       (p_we),
        .p_addr     (p_addr),
        .p_data     (p_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_addr     (s_addr),
        .s_data     (s_data),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask),
        .pipe_stall (pipe_stall),
        .init_busy  (init_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (q[i]) m[q[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_run       = !INIT_EN;
        m_alive     = 1'b0;
        m_init_step = 0;
        m_wait      = 0;
        m_stall     = 1'b0;
        m_we        = 1'b0;
        m_addr      = '0;
        m_data      = '0;
    endtask

    task automatic check_outputs();
        if (rf_we) $display("WR x%0d <= 0x%08h @%0t", rf_addr, rf_wdata, $time);
        check_val("rf_we", rf_we, m_we);
        if (m_we) begin
            check_val("rf_addr", rf_addr, m_addr);
            check_val("rf_wdata", rf_wdata, m_data);
        end
        check_val("s_ready", s_ready, m_run && m_alive && (q.size() < DEPTH));
        check_val("pend_mask", pend_mask, model_pend());
        check_val("pipe_stall", pipe_stall, m_stall);
        check_val("init_busy", init_busy, !m_run);
    endtask

    // Drive one cycle of inputs, advance the model, then check the next cycle.
    task automatic cycle(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic sv, input logic [4:0] sa, input logic [31:0] sd);
        ent_t e;
        bit   ready_now;
        bit   had_head;
        bit   popped;
        p_we = pw; p_addr = pa; p_data = pd;
        s_valid = sv; s_addr = sa; s_data = sd;
        ready_now = m_run && m_alive && (q.size() < DEPTH);
        had_head  = (q.size() != 0);
        popped    = 1'b0;
        m_we = 1'b0; m_addr = '0; m_data = '0;
        if (!m_run) begin
            if (m_init_step < 31) begin
                m_we   = 1'b1;
                m_addr = 5'(m_init_step + 1);
            end else begin
                m_run = 1'b1;
            end
            m_init_step++;
        end else if (pw && pa != 5'd0) begin
            m_we = 1'b1; m_addr = pa; m_data = pd;
        end else if (had_head) begin
            e = q.pop_front();
            m_we = 1'b1; m_addr = e.a; m_data = e.d;
            popped = 1'b1;
        end
        if (popped) begin
            m_wait  = 0;
            m_stall = 1'b0;
        end else begin
            if (had_head) m_wait++;
            if (m_wait >= STARVE_LIMIT) m_stall = 1'b1;
        end
        if (sv && ready_now && sa != 5'd0) begin
            e.a = sa; e.d = sd;
            q.push_back(e);
        end
        m_alive = 1'b1;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0; p_we = 1'b0; s_valid = 1'b0;
        #1;
        check_val("rst_rf_we", rf_we, 1'b0);
        check_val("rst_rf_addr", rf_addr, 5'd0);
        check_val("rst_rf_wdata", rf_wdata, 32'd0);
        check_val("rst_s_ready", s_ready, 1'b0);
        check_val("rst_pend", pend_mask, 32'd0);
        check_val("rst_stall", pipe_stall, 1'b0);
        check_val("rst_init_busy", init_busy, INIT_EN);
        @(negedge clk);
        @(negedge clk);
        check_val("rst_hold_we", rf_we, 1'b0);
        check_val("rst_hold_pend", pend_mask, 32'd0);
        rst = 1'b1;
        model_reset();
    endtask

    task automatic run_init_window(input string tag);
        int wr_cnt;
        wr_cnt = 0;
        for (int i = 0; i < 33; i++) begin
            idle();
            if (rf_we) wr_cnt++;
        end
        check_val(tag, wr_cnt, INIT_EN ? 31 : 0);
    endtask

    initial begin
        logic [31:0] pm;
        int          pw_pct;
        logic        pw;
        logic [4:0]  pa, sa;

        #2;
        do_reset();

        // zero-init sweep (or quiet start when compiled out)
        run_init_window("init_writes");
        check_val("init_done_busy", init_busy, 1'b0);
        check_val("init_done_ready", s_ready, 1'b1);

        // single pipeline write
        cycle(1'b1, 5'd5, 32'hA5, 1'b0, 5'd0, 32'd0);
        check_val("pipe_we", rf_we, 1'b1);
        check_val("pipe_addr", rf_addr, 5'd5);
        check_val("pipe_data", rf_wdata, 32'hA5);

        // fill FIFO behind a busy pipeline, then drain in order
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'd3, 32'h33 + i, 1'b1, 5'(6 + i), 32'h600 + i);
        end
        check_val("full_sready", s_ready, 1'b0);
        check_val("full_pend", pend_mask, 32'h3C0);
        pm = 32'h3C0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            pm[6 + k] = 1'b0;
            check_val("drain_addr", rf_addr, 5'(6 + k));
            check_val("drain_data", rf_wdata, 32'h600 + k);
            check_val("drain_pend", pend_mask, pm);
        end

        // x0 from both sources
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        check_val("x0_we", rf_we, 1'b0);
        check_val("x0_pend", pend_mask, 32'd0);
        idle();
        check_val("x0_we_after", rf_we, 1'b0);

        // starvation: head blocked for STARVE_LIMIT cycles
        cycle(1'b1, 5'd3, 32'h1, 1'b1, 5'd20, 32'h2020);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            if (i == STARVE_LIMIT - 1) check_val("starve_pre", pipe_stall, 1'b0);
            cycle(1'b1, 5'd3, 32'h100 + i, 1'b0, 5'd0, 32'd0);
        end
        check_val("starve_stall", pipe_stall, 1'b1);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check_val("starve_pop_addr", rf_addr, 5'd20);
        check_val("starve_clear", pipe_stall, 1'b0);

        // reset with entries pending
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 5'd3, 32'h7, 1'b1, 5'(10 + i), 32'hA000 + i);
        end
        check_val("pre_rst_pend", pend_mask, 32'h1C00);
        do_reset();
        idle();
        check_val("reinit_we", rf_we, INIT_EN);
        check_val("reinit_pend", pend_mask, 32'd0);
        run_init_window("reinit_writes");

        // randomized traffic, one mid-run reset
        pw_pct = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) pw_pct = $urandom_range(10, 95);
            if (n == 750) begin
                do_reset();
            end
            pw = ($urandom_range(0, 99) < pw_pct) && !pipe_stall;
            pa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            sa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(pw, pa, $urandom(), ($urandom_range(0, 99) < 60), sa, $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
